// File: rtl/register_fetch_controller_if.sv
// rtl/register_fetch_controller_if.sv - decode/execute/writeback/register-file signal bundle for the fetch controller
interface register_fetch_controller_if #(
  parameter int WORD_SIZE = 8,
  parameter int REG_BITS  = 3
);
  logic                 req_valid;
  logic                 req_ready;
  logic [REG_BITS-1:0]  req_src1;
  logic [REG_BITS-1:0]  req_src2;
  logic                 req_wr;
  logic [REG_BITS-1:0]  req_dst;
  logic                 op_valid;
  logic                 op_ready;
  logic [WORD_SIZE-1:0] op_a;
  logic [WORD_SIZE-1:0] op_b;
  logic                 wb_valid;
  logic [REG_BITS-1:0]  wb_num;
  logic [WORD_SIZE-1:0] wb_val;
  logic [REG_BITS-1:0]  rf_num1;
  logic [REG_BITS-1:0]  rf_num2;
  logic                 rf_get_enable;
  logic [REG_BITS-1:0]  rf_set_num;
  logic [WORD_SIZE-1:0] rf_set_val;
  logic                 rf_set_enable;
  logic                 rf_reset_enable;
  logic [WORD_SIZE-1:0] rf_out1;
  logic [WORD_SIZE-1:0] rf_out2;

  // master is the fetch controller; slave is its surroundings (decode, execute, writeback, register file)
  modport master (
    input  req_valid, req_src1, req_src2, req_wr, req_dst,
    input  op_ready, wb_valid, wb_num, wb_val, rf_out1, rf_out2,
    output req_ready, op_valid, op_a, op_b,
    output rf_num1, rf_num2, rf_get_enable, rf_set_num, rf_set_val,
    output rf_set_enable, rf_reset_enable
  );

  modport slave (
    output req_valid, req_src1, req_src2, req_wr, req_dst,
    output op_ready, wb_valid, wb_num, wb_val, rf_out1, rf_out2,
    input  req_ready, op_valid, op_a, op_b,
    input  rf_num1, rf_num2, rf_get_enable, rf_set_num, rf_set_val,
    input  rf_set_enable, rf_reset_enable
  );
endinterface

// File: rtl/register_fetch_controller.sv
// rtl/register_fetch_controller.sv - operand fetch controller with pending-write scoreboard and writeback forwarding
module register_fetch_controller #(
  parameter int WORD_SIZE = 8,
  parameter int NUM_REGS  = 8,
  parameter int REG_BITS  = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  register_fetch_controller_if.master bus
);
  typedef enum logic [1:0] {INIT, IDLE, READ, HOLD} state_t;

  state_t               state;
  logic [NUM_REGS-1:0]  pending;
  logic [NUM_REGS-1:0]  pending_next;
  logic                 fwd1;
  logic                 fwd2;
  logic [WORD_SIZE-1:0] fwd_val;
  logic                 hit1;
  logic                 hit2;
  logic                 stall;
  logic                 accept;

  // A writeback landing this cycle resolves the hazard it would otherwise raise
  assign hit1   = bus.wb_valid && (bus.wb_num == bus.req_src1);
  assign hit2   = bus.wb_valid && (bus.wb_num == bus.req_src2);
  assign stall  = (pending[bus.req_src1] && !hit1) || (pending[bus.req_src2] && !hit2);

  assign bus.req_ready       = (state == IDLE) && !stall && !reset;
  assign accept              = bus.req_valid && bus.req_ready;
  assign bus.rf_get_enable   = accept;
  assign bus.rf_num1         = bus.req_src1;
  assign bus.rf_num2         = bus.req_src2;
  assign bus.rf_set_num      = bus.wb_num;
  assign bus.rf_set_val      = bus.wb_val;
  assign bus.rf_set_enable   = bus.wb_valid && !reset && (state != INIT);
  assign bus.rf_reset_enable = reset || (state == INIT);

  // Clear before set so a new writer of the same register keeps it pending
  always_comb begin
    pending_next = pending;
    if (bus.rf_set_enable) pending_next[bus.wb_num] = 1'b0;
    if (accept && bus.req_wr) pending_next[bus.req_dst] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= INIT;
      pending      <= '0;
      bus.op_valid <= 1'b0;
      bus.op_a     <= '0;
      bus.op_b     <= '0;
      fwd1         <= 1'b0;
      fwd2         <= 1'b0;
      fwd_val      <= '0;
    end else begin
      pending <= pending_next;
      case (state)
        INIT: state <= IDLE;
        IDLE: begin
          if (accept) begin
            fwd1    <= hit1;
            fwd2    <= hit2;
            fwd_val <= bus.wb_val;
            state   <= READ;
          end
        end
        READ: begin
          // The file returns the pre-write value when read and write share an edge
          bus.op_a     <= fwd1 ? fwd_val : bus.rf_out1;
          bus.op_b     <= fwd2 ? fwd_val : bus.rf_out2;
          bus.op_valid <= 1'b1;
          state        <= HOLD;
        end
        HOLD: begin
          if (bus.op_ready) begin
            bus.op_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_register_fetch_controller.sv
// tb/tb_register_fetch_controller.sv - directed self-checking bench for register_fetch_controller
module tb_register_fetch_controller;
  localparam int WORD_SIZE = 8;
  localparam int REG_BITS  = 3;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  register_fetch_controller_if #(.WORD_SIZE(WORD_SIZE), .REG_BITS(REG_BITS)) bus ();

  register_fetch_controller #(.WORD_SIZE(WORD_SIZE), .NUM_REGS(8), .REG_BITS(REG_BITS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Register file: read index sampled on the same edge a write commits, returning the old value
  logic [WORD_SIZE-1:0] rf_regs [8];
  always @(posedge clock) begin
    if (bus.rf_reset_enable) begin
      for (int i = 0; i < 8; i++) rf_regs[i] <= '0;
    end else if (bus.rf_set_enable) begin
      rf_regs[bus.rf_set_num] <= bus.rf_set_val;
    end
    if (bus.rf_get_enable) begin
      bus.rf_out1 <= rf_regs[bus.rf_num1];
      bus.rf_out2 <= rf_regs[bus.rf_num2];
    end
  end

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic request(input int s1, input int s2, input logic wr, input int dst);
    bus.req_valid = 1'b1;
    bus.req_src1  = REG_BITS'(s1);
    bus.req_src2  = REG_BITS'(s2);
    bus.req_wr    = wr;
    bus.req_dst   = REG_BITS'(dst);
  endtask

  task automatic writeback(input logic v, input int num, input int val);
    bus.wb_valid = v;
    bus.wb_num   = REG_BITS'(num);
    bus.wb_val   = WORD_SIZE'(val);
  endtask

  task automatic consume(input string tag);
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
    chk(tag, 32'(bus.op_valid), 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_src1 = '0; bus.req_src2 = '0; bus.req_wr = 1'b0; bus.req_dst = '0;
    bus.op_ready = 1'b0;
    writeback(1'b0, 0, 0);
    #2;

    // Reset: three reset cycles plus one INIT cycle of register-file clear
    for (int c = 0; c < 3; c++) begin
      chk("rst_rf_reset", 32'(bus.rf_reset_enable), 1);
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      tick();
      chk("rst_op_valid", 32'(bus.op_valid), 0);
    end
    chk("rst_op_a", 32'(bus.op_a), 0);
    reset = 1'b0;
    #1;
    chk("init_rf_reset", 32'(bus.rf_reset_enable), 1);
    chk("init_req_ready", 32'(bus.req_ready), 0);
    tick();
    chk("idle_rf_reset", 32'(bus.rf_reset_enable), 0);
    chk("idle_req_ready", 32'(bus.req_ready), 1);

    // Preload R2 and R5 through writeback
    writeback(1'b1, 2, 'h5A);
    #1;
    chk("preload_set_en", 32'(bus.rf_set_enable), 1);
    tick();
    writeback(1'b1, 5, 'hC3);
    tick();
    writeback(1'b0, 0, 0);

    // Basic fetch
    request(2, 5, 1'b0, 0);
    #1;
    chk("basic_ready", 32'(bus.req_ready), 1);
    chk("basic_get_en", 32'(bus.rf_get_enable), 1);
    chk("basic_num1", 32'(bus.rf_num1), 2);
    chk("basic_num2", 32'(bus.rf_num2), 5);
    tick();
    chk("basic_get_once", 32'(bus.rf_get_enable), 0);
    chk("basic_not_yet", 32'(bus.op_valid), 0);
    tick();
    chk("basic_valid", 32'(bus.op_valid), 1);
    chk("basic_op_a", 32'(bus.op_a), 'h5A);
    chk("basic_op_b", 32'(bus.op_b), 'hC3);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("hold_valid", 32'(bus.op_valid), 1);
      chk("hold_op_a", 32'(bus.op_a), 'h5A);
      chk("hold_op_b", 32'(bus.op_b), 'hC3);
      chk("hold_ready", 32'(bus.req_ready), 0);
    end
    bus.req_valid = 1'b0;
    consume("basic_consume");

    // Scoreboard stall: A writes R3, B reads R3 and waits for its writeback
    request(0, 1, 1'b1, 3);
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("a_valid", 32'(bus.op_valid), 1);
    consume("a_consume");
    request(3, 2, 1'b0, 0);
    #1;
    chk("b_stall0", 32'(bus.req_ready), 0);
    tick();
    chk("b_stall1", 32'(bus.req_ready), 0);
    chk("b_no_get", 32'(bus.rf_get_enable), 0);
    writeback(1'b1, 3, 'h77);
    #1;
    chk("b_ready_wb", 32'(bus.req_ready), 1);
    chk("b_get_en", 32'(bus.rf_get_enable), 1);
    tick();
    writeback(1'b0, 0, 0);
    bus.req_valid = 1'b0;
    tick();
    chk("b_op_a_fwd", 32'(bus.op_a), 'h77);
    chk("b_op_b", 32'(bus.op_b), 'h5A);
    consume("b_consume");

    // Same-cycle forwarding on a non-pending register
    request(4, 4, 1'b0, 0);
    writeback(1'b1, 4, 'h11);
    #1;
    chk("fwd_ready", 32'(bus.req_ready), 1);
    tick();
    writeback(1'b0, 0, 0);
    bus.req_valid = 1'b0;
    tick();
    chk("fwd_op_a", 32'(bus.op_a), 'h11);
    chk("fwd_op_b", 32'(bus.op_b), 'h11);
    consume("fwd_consume");
    request(4, 3, 1'b0, 0);
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("r4_file_a", 32'(bus.op_a), 'h11);
    chk("r4_file_b", 32'(bus.op_b), 'h77);
    consume("r4_consume");

    // Set wins over a same-edge clear of R6
    request(0, 0, 1'b1, 6);
    writeback(1'b1, 6, 'h99);
    tick();
    writeback(1'b0, 0, 0);
    bus.req_valid = 1'b0;
    tick();
    consume("sw_consume");
    request(0, 6, 1'b0, 0);
    #1;
    chk("sw_stall0", 32'(bus.req_ready), 0);
    tick();
    chk("sw_stall1", 32'(bus.req_ready), 0);
    request(6, 0, 1'b1, 7);
    writeback(1'b1, 6, 'hAB);
    #1;
    chk("sw_release", 32'(bus.req_ready), 1);
    tick();
    writeback(1'b0, 0, 0);
    bus.req_valid = 1'b0;
    tick();
    chk("sw_valid", 32'(bus.op_valid), 1);
    chk("sw_op_a", 32'(bus.op_a), 'hAB);

    // Reset during HOLD aborts the fetch and drops writebacks
    reset = 1'b1;
    writeback(1'b1, 1, 'hEE);
    #1;
    chk("hr_set_en", 32'(bus.rf_set_enable), 0);
    chk("hr_rf_reset", 32'(bus.rf_reset_enable), 1);
    tick();
    chk("hr_op_valid", 32'(bus.op_valid), 0);
    reset = 1'b0;
    #1;
    chk("hr_init_reset", 32'(bus.rf_reset_enable), 1);
    chk("hr_init_set_en", 32'(bus.rf_set_enable), 0);
    tick();
    writeback(1'b0, 0, 0);
    request(7, 6, 1'b0, 0);
    #1;
    chk("hr_pending_clr", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("hr_op_a", 32'(bus.op_a), 0);
    chk("hr_op_b", 32'(bus.op_b), 0);
    consume("hr_consume");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
